// File: rtl/uart_pkg.sv
// Shared UART definitions: oversample arithmetic, TX state encoding and default word size.
// Used by both the transmitter and the receiver so both ends derive identical baud timing.
package uart_pkg;

  localparam int OVERSAMPLE_RATE    = 16;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int cycles_per_tick(input int clk_freq, input int baud_rate);
    return clk_freq / (baud_rate * OVERSAMPLE_RATE);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 while enabled and pulses bit_done_o on the last cycle.
// Held at zero when disabled or cleared, so it never free-runs between frames.
module uart_baud_gen #(
  parameter int BIT_CYCLES = 432
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic bit_done_o
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_done_o = en_i && !clr_i && (cnt_q == CW'(BIT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i || bit_done_o) cnt_d = '0;
    else                              cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, even parity, stop bit; TxD registered.
// Optional UART_TX_PARITY_INJECT_EN adds force_parity_err to transmit inverted parity.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] TxData,
  input  logic                  tx_valid,
`ifdef UART_TX_PARITY_INJECT_EN
  input  logic                  force_parity_err,
`endif
  output logic                  tx_ready,
  output logic                  TxD,
  output logic                  tx_busy
);

  localparam int BIT_CYCLES = cycles_per_tick(CLK_FREQ, BAUD_RATE) * OVERSAMPLE_RATE;
  localparam int IW         = $clog2(DATA_WIDTH) + 1;

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic                  parity_q, parity_d;
  logic                  txd_q, txd_d;
  logic                  accept, bit_done, par_in;

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = !tx_ready;
  assign TxD      = txd_q;
  assign accept   = tx_valid && tx_ready;

`ifdef UART_TX_PARITY_INJECT_EN
  assign par_in = (^TxData) ^ force_parity_err;
`else
  assign par_in = ^TxData;
`endif

  uart_baud_gen #(.BIT_CYCLES(BIT_CYCLES)) u_baud (
    .clk       (clk),
    .rst_n     (reset),
    .en_i      (state_q != IDLE),
    .clr_i     (accept),
    .bit_done_o(bit_done)
  );

  // txd_d always holds the level of the *next* bit so TxD only moves on bit boundaries.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    parity_d  = parity_q;
    txd_d     = txd_q;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (accept) begin
          shift_d   = TxData;
          parity_d  = par_in;
          bit_idx_d = '0;
          txd_d     = 1'b0;
          state_d   = START;
        end
      end
      START: if (bit_done) begin
        txd_d   = shift_q[0];
        state_d = DATA;
      end
      DATA: if (bit_done) begin
        shift_d   = shift_q >> 1;
        bit_idx_d = bit_idx_q + IW'(1);
        if (bit_idx_q == IW'(DATA_WIDTH - 1)) begin
          txd_d   = parity_q;
          state_d = PARITY;
        end else begin
          txd_d = shift_d[0];
        end
      end
      PARITY: if (bit_done) begin
        txd_d   = 1'b1;
        state_d = STOP;
      end
      STOP: if (bit_done) state_d = IDLE;
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      parity_q  <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      parity_q  <= parity_d;
      txd_q     <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes expected frames, a line monitor decodes TxD and checks them.
module tb_uart_tx;

  localparam int BIT_CYCLES = 432;
  localparam int NB         = 11;
  localparam int FRAME      = NB * BIT_CYCLES;

  logic       clk;
  logic       rst_n;
  logic [7:0] TxData;
  logic       tx_valid;
  logic       fpe;
  logic       tx_ready, TxD, tx_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int frames_done = 0;

  logic [10:0] exp_q[$];
  int          acc_q[$];
  int          acc_hist[$];

  uart_tx dut (
    .clk     (clk),
    .reset   (rst_n),
    .TxData  (TxData),
    .tx_valid(tx_valid),
`ifdef UART_TX_PARITY_INJECT_EN
    .force_parity_err(fpe),
`endif
    .tx_ready(tx_ready),
    .TxD     (TxD),
    .tx_busy (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  // Reference line image of one frame: start, data LSB first, parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] w, input logic inj);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = w[i];
    f[9]  = (($countones(w) % 2) == 1) ^ inj;
    f[10] = 1'b1;
    return f;
  endfunction

  // Cycle counter and accept log.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
        acc_q.push_back(cyc);
        acc_hist.push_back(cyc);
      end
    end
  end

  // Line monitor: decodes each frame from TxD and checks it against the scoreboard.
  initial begin : monitor
    logic [10:0] got;
    bit          held, aborted;
    int          start_c;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && TxD === 1'b0) begin
        start_c = cyc;
        held    = 1'b1;
        aborted = 1'b0;
        got     = '0;
        for (int b = 0; b < NB && !aborted; b++) begin
          for (int c = 0; c < BIT_CYCLES && !aborted; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst_n !== 1'b1) aborted = 1'b1;
            else begin
              if (c == 0) got[b] = TxD;
              else if (TxD !== got[b]) held = 1'b0;
              if (tx_busy !== 1'b1 || tx_ready !== 1'b0) held = 1'b0;
            end
          end
        end
        if (!aborted) begin
          chk("bit_hold", {31'd0, held}, 32'd1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame actual=%0h required=none", got);
          end else begin
            chk("frame_bits", {21'd0, got}, {21'd0, exp_q.pop_front()});
          end
          if (acc_q.size() != 0) chk("start_latency", start_c, acc_q.pop_front());
          @(negedge clk);
          chk("gap_idle", {30'd0, TxD, tx_ready}, 32'd3);
          frames_done++;
        end
      end
    end
  end

  task automatic wait_frames(input int n);
    int k = 0;
    while (frames_done < n && k < FRAME + 1500) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (frames_done < n) begin
      total++;
      bad++;
      $display("FAIL frame_timeout actual=%0d required=%0d", frames_done, n);
    end
  endtask

  task automatic send(input logic [7:0] w, input logic inj);
    int k = 0;
    while (tx_ready !== 1'b1 && k < FRAME + 1500) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (tx_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL send_ready_timeout actual=%b required=1", tx_ready);
    end
    exp_q.push_back(frame_of(w, inj));
    TxData   = w;
    tx_valid = 1'b1;
    fpe      = inj;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    fpe      = 1'b0;
    TxData   = 8'($urandom);
  endtask

  initial begin : stim
    int n0, k;
    rst_n    = 1'b1;
    tx_valid = 1'b0;
    TxData   = 8'h00;
    fpe      = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_txd", TxD, 1);
    chk("reset_ready", tx_ready, 1);
    chk("reset_busy", tx_busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send(8'h55, 1'b0);
    wait_frames(1);
    send(8'h07, 1'b0);
    wait_frames(2);

    // Valid held high across two frames; second word must go out one idle cycle later.
    exp_q.push_back(frame_of(8'hA5, 1'b0));
    exp_q.push_back(frame_of(8'h3C, 1'b0));
    n0 = acc_hist.size();
    TxData   = 8'hA5;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    TxData = 8'h3C;
    k = 0;
    while (acc_hist.size() < n0 + 2 && k < 2 * FRAME) begin
      @(posedge clk);
      #1;
      k++;
    end
    tx_valid = 1'b0;
    chk("b2b_accepts", acc_hist.size() - n0, 2);
    if (acc_hist.size() >= n0 + 2)
      chk("b2b_spacing", acc_hist[n0+1] - acc_hist[n0], FRAME + 1);
    wait_frames(4);

    // Mid-frame valid pulse with a new word must be ignored.
    send(8'h12, 1'b0);
    repeat (2000) @(posedge clk);
    #1;
    chk("busy_ready_low", tx_ready, 0);
    TxData   = 8'hFF;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    chk("still_busy", tx_busy, 1);
    wait_frames(5);
    repeat (20) @(posedge clk);
    #1;
    chk("no_queued_frame", tx_ready, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    // Asynchronous reset during data bit 3 (a zero bit of 0x34).
    send(8'h34, 1'b0);
    repeat (1900) @(posedge clk);
    @(negedge clk);
    #2;
    chk("pre_rst_bit3", TxD, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_txd", TxD, 1);
    chk("rst_mid_ready", tx_ready, 1);
    chk("rst_mid_busy", tx_busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    acc_q.delete();
    chk("post_rst_ready", tx_ready, 1);
    send(8'h81, 1'b0);
    wait_frames(6);

    send(8'hC3, 1'b0);
    wait_frames(7);

    for (int i = 0; i < 3; i++) begin
      send(8'($urandom_range(0, 255)), 1'b0);
      wait_frames(8 + i);
    end

`ifdef UART_TX_PARITY_INJECT_EN
    send(8'hC3, 1'b1);
    wait_frames(11);
`endif

    repeat (10) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for the UART link; the upstream stage that drives the TxD line sampled by the receiver.
- Accepts a parallel word over a valid/ready handshake and serialises it as one frame: start bit (0), DATA_WIDTH data bits LSB first, even-parity bit, stop bit (1).
- Bit period is derived from the same 16x oversample arithmetic as the receiver, so both ends agree on baud timing at any CLK_FREQ/BAUD_RATE pair.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s.
- DATA_WIDTH, 8, data bits per frame.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- TxData  input  DATA_WIDTH  word to transmit; sampled only on an accepted handshake.
- tx_valid  input  1  TxData is valid.
- tx_ready  output  1  block can accept a word this cycle.
- TxD  output  1  serial line, idles high.
- tx_busy  output  1  a frame is in progress (any state other than IDLE).

Behaviour:
- Timing constants:
  - CYCLES_PER_TICK = CLK_FREQ / (BAUD_RATE*16), integer truncation.
  - BIT_CYCLES = CYCLES_PER_TICK*16. Every line bit lasts exactly BIT_CYCLES clocks.
  - At the defaults: CYCLES_PER_TICK = 27, BIT_CYCLES = 432.
- Reset values (applied asynchronously, held while reset = 0): TxD = 1, tx_ready = 1, tx_busy = 0, state = IDLE, all counters = 0, shift register = 0.
- States: IDLE, START, DATA, PARITY, STOP (encoded as a 3-bit enum).
- IDLE:
  - TxD = 1, tx_ready = 1.
  - Accept on tx_valid && tx_ready at a rising edge. On that edge:
    - latch TxData into the shift register;
    - compute parity = ^TxData;
    - clear the counters;
    - move to START.
- START: TxD = 0 for BIT_CYCLES, then move to DATA.
- DATA:
  - TxD = shift[0]. After each BIT_CYCLES, shift right by 1 and increment bit_idx.
  - After the DATA_WIDTH-th bit completes, move to PARITY.
  - bit_idx width is $clog2(DATA_WIDTH)+1.
- PARITY: TxD = latched parity for BIT_CYCLES, then move to STOP.
- STOP: TxD = 1 for BIT_CYCLES, then move to IDLE.
- Output timing:
  - TxD is registered and changes only on state or bit boundaries (glitch-free).
  - tx_ready = (state == IDLE); tx_busy = !tx_ready.
- Latency:
  - Accept edge at t0. The start bit occupies cycles t0+1 through t0+BIT_CYCLES.
  - The frame ends at t0+(DATA_WIDTH+3)*BIT_CYCLES.
  - tx_ready is high again on the following cycle.
- Back-to-back: at least one IDLE cycle (TxD = 1) separates frames. Holding tx_valid high sends consecutive frames with exactly that 1-cycle gap.
- tx_valid and TxData changes while busy are ignored. The frame uses only the latched word.
- Reset mid-frame: TxD returns to 1 immediately. The frame is aborted and not resumed; after release the block is in IDLE, ready.
- cycle_counter counts 0..BIT_CYCLES-1 and wraps to 0 at each bit boundary; it is never left free-running in IDLE.

Optional Feature:
- Macro: UART_TX_PARITY_INJECT_EN.
- With the macro defined:
  - Extra input port force_parity_err (1 bit), sampled with the handshake.
  - If the sampled value is 1, the transmitted parity bit is ~(^TxData), for receiver error-detection testing.
- Without the macro: the port is absent and parity is always even.

Decomposition:
- uart_pkg holds:
  - OVERSAMPLE_RATE = 16;
  - function cycles_per_tick(CLK_FREQ, BAUD_RATE);
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_WIDTH default constant.
- The receiver shares the package.
- Sub-module uart_baud_gen:
  - BIT_CYCLES counter with enable and clear inputs;
  - emits a 1-cycle bit_done pulse;
  - reusable by the receiver.

Test Plan:
- Defaults, send 0x55 → TxD = 0,1,0,1,0,1,0,1,0, parity 0, stop 1; each level held exactly 432 cycles; frame = 4752 cycles.
- Send 0x07 (three ones) → parity bit 1; data bits 1,1,1,0,0,0,0,0.
- tx_valid held high with 0xA5 then 0x3C; first accepted at t0:
  - tx_ready rises at t0+4753 and 0x3C is accepted on that edge;
  - second start bit begins at t0+4754;
  - TxD = 1 during the gap cycle.
- Change TxData to 0xFF and pulse tx_valid mid-frame of 0x12 → line still carries 0x12; tx_ready stays 0; no second frame queued.
- Assert reset during data bit 3 → TxD = 1, tx_ready = 1, tx_busy = 0 without waiting for a clock edge; after release, sending 0x81 produces a clean full frame.
- Loopback into the receiver, send 0xC3 → receiver RxData = 0xC3, valid_rx = 1. With UART_TX_PARITY_INJECT_EN and force_parity_err = 1 → valid_rx = 0.
